// File: rtl/truth_table_sweeper_pkg.sv
// Shared state encoding and default sizing for the truth-table sweeper.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N_IN  = 4;
    localparam int DEF_CODES = 1 << DEF_N_IN;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter pacing how long each code is held before sampling.
module truth_table_sweeper_settle_counter #(
    parameter int SETTLE = 1,
    parameter int CW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam logic [CW-1:0] RELOAD = CW'(SETTLE);

    logic [CW-1:0] cnt;

    // Reaching zero while enabled is the sample point, so reload there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (load || (en && zero))
            cnt <= RELOAD;
        else if (en)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a combinational block through every input code and records its truth table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   hold,
    input  logic                   f_in,
    output logic [N_IN-1:0]        w_out,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          count_out,
    output logic                   busy,
    output logic                   done
);

    localparam int              CODES = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST  = N_IN'(CODES - 1);

    state_t state;
    logic   zero;
    logic   sample;

    assign sample = (state == DRIVE) && !hold && zero;

    truth_table_sweeper_settle_counter #(.SETTLE(SETTLE)) u_settle_counter (
        .clk  (clk),
        .rstn (rstn),
        .load ((state == IDLE) && start),
        .en   ((state == DRIVE) && !hold),
        .zero (zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            w_out     <= '0;
            table_out <= '0;
            count_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    w_out <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        state     <= DRIVE;
                        busy      <= 1'b1;
                        table_out <= '0;
                        count_out <= '0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        table_out[w_out] <= f_in;
                        count_out        <= count_out + {{N_IN{1'b0}}, f_in};
                        // The last code stays on the bus through the DONE cycle.
                        if (w_out == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            w_out <= w_out + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    w_out <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: sweep-position model checked every cycle plus literal result pins.
module tb_truth_table_sweeper;

    localparam int S = 1;

    logic        clk = 1'b0;
    logic        rstn, start, hold, f_a;
    logic [1:0]  mode;
    logic [3:0]  w_a;
    logic [15:0] table_a;
    logic [4:0]  count_a;
    logic        busy_a, done_a;

    logic        start_b, f_b;
    logic [3:0]  w_b;
    logic [15:0] table_b;
    logic [4:0]  count_b;
    logic        busy_b, done_b;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    function automatic logic fm(input logic [1:0] md, input int w);
        logic [3:0] wv;
        wv = w[3:0];
        case (md)
            2'd0:    return ^wv;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return (wv == 4'b0101);
        endcase
    endfunction

    assign f_a = fm(mode, int'(w_a));
    assign f_b = ^w_b;

    truth_table_sweeper #(.N_IN(4), .SETTLE(S)) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .hold(hold), .f_in(f_a),
        .w_out(w_a), .table_out(table_a), .count_out(count_a),
        .busy(busy_a), .done(done_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .hold(1'b0), .f_in(f_b),
        .w_out(w_b), .table_out(table_b), .count_out(count_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: p counts un-held DRIVE cycles; the code is p/(S+1), sampled on its last cycle.
    int          m_state, m_p, m_count;
    logic [15:0] m_table;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state <= 0; m_p <= 0; m_table <= '0; m_count <= 0;
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state <= 1; m_p <= 0; m_table <= '0; m_count <= 0;
                end
                1: if (!hold) begin
                    m_p <= m_p + 1;
                    if (m_p % (S + 1) == S) begin
                        m_table[m_p / (S + 1)] <= fm(mode, m_p / (S + 1));
                        m_count <= m_count + int'(fm(mode, m_p / (S + 1)));
                        if (m_p == 16 * (S + 1) - 1) m_state <= 2;
                    end
                end
                default: m_state <= 0;
            endcase
        end
    end

    function automatic int m_w();
        if (m_state == 1) return m_p / (S + 1);
        if (m_state == 2) return 15;
        return 0;
    endfunction

    always @(posedge clk) begin
        #2;
        if (rstn) begin
            chk("busy", 32'(busy_a), 32'(m_state == 1));
            chk("done", 32'(done_a), 32'(m_state == 2));
            chk("w_out", 32'(w_a), 32'(m_w()));
            chk("table_out", 32'(table_a), 32'(m_table));
            chk("count_out", 32'(count_a), 32'(m_count));
        end
    end

    task automatic sweep_a(input logic [1:0] md, input bit do_hold, input bit do_restart,
                           input bit do_reset, output int done_cyc, output int busy_cyc,
                           output int w3_cyc, output int ndone);
        int cyc, hold_left, post;
        bit hdone;
        cyc = 0; hold_left = 0; post = -1; hdone = 0;
        done_cyc = -1; busy_cyc = 0; w3_cyc = 0; ndone = 0;
        @(negedge clk);
        mode = md; start = 1'b1; hold = 1'b0;
        @(posedge clk);
        while (cyc < 120 && post != 0) begin
            @(negedge clk);
            cyc++;
            start = do_restart && (cyc == 5 || cyc == 33);
            if (busy_a) busy_cyc++;
            if (busy_a && w_a == 4'd3) w3_cyc++;
            if (done_a) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                post = 4;
            end else if (post > 0) begin
                post--;
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end else if (do_hold && w_a == 4'd3 && !hdone) begin
                hold = 1'b1; hold_left = 7; hdone = 1'b1;
            end
            if (do_reset && busy_a && w_a == 4'd9) begin
                #2 rstn = 1'b0;
                #1;
                chk("rst w_out", 32'(w_a), 0);
                chk("rst table", 32'(table_a), 0);
                chk("rst count", 32'(count_a), 0);
                chk("rst busy", 32'(busy_a), 0);
                #1 rstn = 1'b1;
                post = 4;
            end
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        int dc, bc, w3, nd, cyc, dcb;
        rstn = 1'b0; start = 1'b0; hold = 1'b0; mode = 2'd0; start_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset w_out", 32'(w_a), 0);
        chk("reset table", 32'(table_a), 0);
        chk("reset count", 32'(count_a), 0);
        chk("reset busy/done", 32'({busy_a, done_a}), 0);
        rstn = 1'b1;
        // hold outside DRIVE is a no-op
        hold = 1'b1;
        repeat (2) @(negedge clk);
        hold = 1'b0;

        sweep_a(2'd0, 0, 0, 0, dc, bc, w3, nd);
        chk("parity done cycle", dc, 33);
        chk("parity busy cycles", bc, 32);
        chk("parity table", 32'(table_a), 32'h6996);
        chk("parity count", 32'(count_a), 8);
        chk("parity done pulses", nd, 1);

        sweep_a(2'd1, 0, 0, 0, dc, bc, w3, nd);
        chk("zero table", 32'(table_a), 32'h0000);
        chk("zero count", 32'(count_a), 0);
        sweep_a(2'd2, 0, 0, 0, dc, bc, w3, nd);
        chk("ones table", 32'(table_a), 32'hFFFF);
        chk("ones count", 32'(count_a), 16);

        sweep_a(2'd3, 1, 0, 0, dc, bc, w3, nd);
        chk("hold w3 cycles", w3, 9);
        chk("hold done cycle", dc, 40);
        chk("hold table", 32'(table_a), 32'h0020);
        chk("hold count", 32'(count_a), 1);

        sweep_a(2'd0, 0, 1, 0, dc, bc, w3, nd);
        chk("restart done pulses", nd, 1);
        chk("restart done cycle", dc, 33);
        chk("restart idle w/busy", 32'({w_a, busy_a, done_a}), 0);

        sweep_a(2'd0, 0, 0, 1, dc, bc, w3, nd);
        chk("abort done pulses", nd, 0);
        chk("abort idle busy", 32'(busy_a), 0);
        sweep_a(2'd0, 0, 0, 0, dc, bc, w3, nd);
        chk("post-abort done cycle", dc, 33);
        chk("post-abort table", 32'(table_a), 32'h6996);

        // SETTLE=0 build: one code per cycle
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        cyc = 0; dcb = -1;
        while (cyc < 40 && dcb < 0) begin
            @(negedge clk);
            start_b = 1'b0;
            cyc++;
            if (cyc <= 16) chk("s0 w_out", 32'(w_b), 32'(cyc - 1));
            if (done_b) dcb = cyc;
        end
        chk("s0 done cycle", dcb, 17);
        chk("s0 table", 32'(table_b), 32'h6996);
        chk("s0 count", 32'(count_b), 8);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that drives a 4-input combinational function block through all 2^N_IN input codes in order. It samples the block's single-bit output after a programmable settle time and assembles the full truth table plus a minterm count. It sits between a lab-board start button/controller and the combinational function under test, replacing manual stimulus with a hardware sweep.

Parameters:
N_IN, 4, width of function input bus W; sweep covers codes 0 .. 2^N_IN-1
SETTLE, 1, extra cycles each code is held before f is sampled (0 allowed); each code is held SETTLE+1 cycles

Ports:
clk  input  1  single clock, rising edge
rstn  input  1  asynchronous, active-low reset
start  input  1  request a sweep; sampled only in IDLE
hold  input  1  pause; freezes sweep state while high in DRIVE
f_in  input  1  output of the combinational function block
w_out  output  N_IN  input code driven to the function block (bit N_IN-1 = MSB)
table_out  output  2^N_IN  truth table; bit k = f sampled with w_out==k
count_out  output  N_IN+1  number of codes for which f_in was 1
busy  output  1  high while sweep in progress (DRIVE)
done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset (rstn=0, asynchronous, takes effect immediately): state=IDLE, w_out=0, table_out=0, count_out=0, busy=0, done=0, settle counter=0.
- All outputs are registered; no combinational path from f_in to any output.
- States: IDLE, DRIVE, DONE.
- IDLE: busy=0, done=0, w_out=0; table_out/count_out hold the last sweep's result.
  - start=1 at an edge -> DRIVE.
  - On the same edge: table_out=0, count_out=0, w_out=0, settle counter=SETTLE.
- DRIVE: busy=1.
  - hold=1 at an edge: no state change at all (counter, w_out, table_out, count_out frozen).
  - hold=0 and counter>0: counter decrements.
  - hold=0 and counter==0 (sample edge): table_out[w_out]<=f_in, count_out<=count_out+f_in, counter reloads SETTLE.
  - At the sample edge, w_out==2^N_IN-1 -> DONE, w_out unchanged. Otherwise w_out<=w_out+1; no wrap inside a sweep.
- DONE: one cycle with done=1, busy=0; then -> IDLE (w_out<=0). start during DONE is ignored.
- start in DRIVE or DONE is ignored (no restart, no queueing).
- Latency with hold=0: start sampled at edge 0; DRIVE spans cycles 1..2^N_IN*(SETTLE+1); done high in the next cycle. For defaults, done is high in cycle 33.
- count_out is N_IN+1 bits so all-ones (16) does not overflow.
- Reset mid-sweep aborts with no done pulse; partial results are cleared to 0.
- hold outside DRIVE has no effect.

Decomposition:
- Shared package/header (lab defines file):
  - state encodings IDLE=2'd0, DRIVE=2'd1, DONE=2'd2
  - localparam CODES=1<<N_IN
- One natural sub-module: settle_counter (loadable down-counter with enable and zero flag), instantiated once.
- FSM, code counter and table/count accumulation stay in the top module.

Test Plan:
- Parity model f=^W, SETTLE=1, pulse start -> w_out steps 0..15, each held 2 cycles; done in cycle 33; table_out=16'h6996; count_out=8; busy high exactly 32 cycles.
- f tied 0, then f tied 1 -> table_out=16'h0000/count_out=0, then table_out=16'hFFFF/count_out=16 (5'b10000); second start clears previous result before sweeping.
- Model f=(W==4'b0101), hold=1 for 7 cycles while w_out==3 -> w_out stays 3 for 9 cycles total; done in cycle 40; table_out=16'h0020; count_out=1.
- start re-pulsed at cycles 5 and 33 (DONE) of a sweep -> ignored; exactly one done pulse; IDLE reached with w_out=0.
- rstn low asynchronously (between edges) while w_out==9 -> outputs go to reset values immediately; no done pulse; a fresh start then sweeps normally from code 0.
- SETTLE=0 build with parity model -> one code per cycle; done in cycle 17; table_out=16'h6996.
